turn_signal_seq: RTL and testbench

//  Parametrised sequential turn-signal / tail-lamp controller for N lamps per side.

---
 rtl/turn_signal_pkg.sv | 17 +
 rtl/step_prescaler.sv | 24 ++
 rtl/turn_signal_seq.sv | 103 ++++++++++
 tb/tb_turn_signal_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/turn_signal_pkg.sv
// Shared encodings for the sequential turn-signal controller.
package turn_signal_pkg;

   localparam logic [1:0] DIR_OFF    = 2'b00;
   localparam logic [1:0] DIR_RIGHT  = 2'b01;
   localparam logic [1:0] DIR_HAZARD = 2'b10;
   localparam logic [1:0] DIR_LEFT   = 2'b11;

   // Mode encoding matches the dir input so a decode is a plain cast.
   typedef enum logic [1:0] {
      MODE_OFF    = DIR_OFF,
      MODE_RIGHT  = DIR_RIGHT,
      MODE_HAZARD = DIR_HAZARD,
      MODE_LEFT   = DIR_LEFT
   } mode_t;

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: counts 0..STEP_TICKS-1, tick on the last count, clr restarts.
module step_prescaler #(
   parameter int unsigned STEP_TICKS = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

   logic [PW-1:0] presc;

   assign tick = (presc == PW'(STEP_TICKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       presc <= '0;
      else if (clr)  presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PW'(1);
   end

endmodule

// File: rtl/turn_signal_seq.sv
// Sequential turn-signal / tail-lamp controller for N_LAMPS per side, with
// prescaled stepping, hazard flash, brake override and optional dark gap.
module turn_signal_seq
   import turn_signal_pkg::*;
#(
   parameter int unsigned N_LAMPS    = 3,
   parameter int unsigned STEP_TICKS = 1,
   parameter int unsigned GAP        = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         dir,
   input  logic               brake,
   output logic [N_LAMPS-1:0] L,
   output logic [N_LAMPS-1:0] R
);

   localparam int unsigned PHW = $clog2(N_LAMPS + 1);

   mode_t          mode_q, mode_n, mode_d;
   logic [PHW-1:0] phase_q, phase_n;
   logic           flash_q, flash_n;
   logic           brake_q;
   logic           mode_chg_c;
   logic           tick;
   logic [N_LAMPS-1:0] therm;

   step_prescaler #(.STEP_TICKS(STEP_TICKS)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .clr  (mode_chg_c),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE_OFF;
         phase_q <= '0;
         flash_q <= 1'b0;
         brake_q <= 1'b0;
      end else begin
         mode_q  <= mode_n;
         phase_q <= phase_n;
         flash_q <= flash_n;
         brake_q <= brake;
      end
   end

   // A mode change wins over tick and restarts the sequence.
   always_comb begin
      mode_d     = mode_t'(dir);
      mode_chg_c = (mode_d != mode_q);
      mode_n     = mode_q;
      phase_n    = phase_q;
      flash_n    = flash_q;
      if (mode_chg_c) begin
         mode_n = mode_d;
         case (mode_d)
            MODE_LEFT, MODE_RIGHT: phase_n = PHW'(1);
            MODE_HAZARD:           flash_n = 1'b1;
            default: begin
               phase_n = '0;
               flash_n = 1'b0;
            end
         endcase
      end else if (tick) begin
         case (mode_q)
            MODE_LEFT, MODE_RIGHT: begin
               if (phase_q == PHW'(N_LAMPS)) phase_n = (GAP != 0) ? '0 : PHW'(1);
               else                          phase_n = phase_q + PHW'(1);
            end
            MODE_HAZARD: flash_n = ~flash_q;
            default:     ;
         endcase
      end
   end

   // Lamp decode from registered state only.
   always_comb begin
      for (int i = 0; i < int'(N_LAMPS); i++) therm[i] = (i < int'(phase_q));
      L = '0;
      R = '0;
      case (mode_q)
         MODE_LEFT: begin
            L = therm;
            R = {N_LAMPS{brake_q}};
         end
         MODE_RIGHT: begin
            L = {N_LAMPS{brake_q}};
            R = therm;
         end
         MODE_HAZARD: begin
            L = {N_LAMPS{flash_q}};
            R = {N_LAMPS{flash_q}};
         end
         default: begin
            L = {N_LAMPS{brake_q}};
            R = {N_LAMPS{brake_q}};
         end
      endcase
   end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed bench for turn_signal_seq across three parameter sets.
module tb_turn_signal_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // A: N=3, STEP=2, GAP=0
   logic       rst_a, brake_a;
   logic [1:0] dir_a;
   logic [2:0] la, ra;
   // B: N=3, STEP=1, GAP=1
   logic       rst_b, brake_b;
   logic [1:0] dir_b;
   logic [2:0] lb, rb;
   // C: N=5, STEP=1, GAP=0
   logic       rst_c, brake_c;
   logic [1:0] dir_c;
   logic [4:0] lc, rc;

   int nchecks = 0;
   int nerr    = 0;

   turn_signal_seq #(.N_LAMPS(3), .STEP_TICKS(2), .GAP(0)) dut_a (
      .clk(clk), .rst(rst_a), .dir(dir_a), .brake(brake_a), .L(la), .R(ra));
   turn_signal_seq #(.N_LAMPS(3), .STEP_TICKS(1), .GAP(1)) dut_b (
      .clk(clk), .rst(rst_b), .dir(dir_b), .brake(brake_b), .L(lb), .R(rb));
   turn_signal_seq #(.N_LAMPS(5), .STEP_TICKS(1), .GAP(0)) dut_c (
      .clk(clk), .rst(rst_c), .dir(dir_c), .brake(brake_c), .L(lc), .R(rc));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [2:0] el, input logic [2:0] er);
      chk({tag, ".L"}, 8'(la), 8'(el));
      chk({tag, ".R"}, 8'(ra), 8'(er));
   endtask

   initial begin
      rst_a = 1'b1; dir_a = 2'b00; brake_a = 1'b0;
      rst_b = 1'b1; dir_b = 2'b00; brake_b = 1'b0;
      rst_c = 1'b1; dir_c = 2'b00; brake_c = 1'b0;
      step(); step();
      chk_a("a_reset", 3'b000, 3'b000);

      // Right sweep at STEP_TICKS=2
      rst_a = 1'b0;
      dir_a = 2'b01;
      step(); chk_a("a_e1", 3'b000, 3'b001);
      step(); chk_a("a_e2", 3'b000, 3'b001);
      step(); chk_a("a_e3", 3'b000, 3'b011);
      step(); chk_a("a_e4", 3'b000, 3'b011);
      step(); chk_a("a_e5", 3'b000, 3'b111);
      step(); chk_a("a_e6", 3'b000, 3'b111);
      step(); chk_a("a_e7", 3'b000, 3'b001);

      // Brake mid-sweep lights the other side, sweep undisturbed
      brake_a = 1'b1;
      step(); chk_a("a_brk8", 3'b111, 3'b001);
      step(); chk_a("a_brk9", 3'b111, 3'b011);
      brake_a = 1'b0;
      step(); chk_a("a_brk10", 3'b000, 3'b011);
      step(); chk_a("a_e11", 3'b000, 3'b111);
      step(); chk_a("a_e12", 3'b000, 3'b111);
      step(); chk_a("a_e13", 3'b000, 3'b001);
      step(); chk_a("a_e14", 3'b000, 3'b001);
      step(); chk_a("a_e15", 3'b000, 3'b011);

      // Switch to left while R=011, braking
      dir_a = 2'b11;
      brake_a = 1'b1;
      step(); chk_a("a_sw16", 3'b001, 3'b111);
      step(); chk_a("a_sw17", 3'b001, 3'b111);
      step(); chk_a("a_sw18", 3'b011, 3'b111);
      brake_a = 1'b0;
      step(); chk_a("a_sw19", 3'b011, 3'b000);

      // Hazard with brake: 2 on, 2 off
      dir_a = 2'b10;
      brake_a = 1'b1;
      step(); chk_a("a_hz20", 3'b111, 3'b111);
      step(); chk_a("a_hz21", 3'b111, 3'b111);
      step(); chk_a("a_hz22", 3'b000, 3'b000);
      step(); chk_a("a_hz23", 3'b000, 3'b000);
      step(); chk_a("a_hz24", 3'b111, 3'b111);

      // Off with brake: both sides lit
      dir_a = 2'b00;
      step(); chk_a("a_offbrk", 3'b111, 3'b111);

      // Async reset while R=111
      brake_a = 1'b0;
      dir_a = 2'b01;
      step(); chk_a("a_r1", 3'b000, 3'b001);
      step(); step(); chk_a("a_r3", 3'b000, 3'b011);
      step(); step(); chk_a("a_r5", 3'b000, 3'b111);
      #2 rst_a = 1'b1;
      #1 chk_a("a_async", 3'b000, 3'b000);
      #1 rst_a = 1'b0;
      step(); chk_a("a_post", 3'b000, 3'b001);

      // GAP=1, STEP_TICKS=1
      dir_b = 2'b01;
      rst_b = 1'b0;
      step(); chk("b_e1", 8'(rb), 8'b001);
      step(); chk("b_e2", 8'(rb), 8'b011);
      step(); chk("b_e3", 8'(rb), 8'b111);
      step(); chk("b_gap", 8'(rb), 8'b000);
      step(); chk("b_e5", 8'(rb), 8'b001);
      chk("b_L", 8'(lb), 8'b000);

      // N_LAMPS=5 left walk
      dir_c = 2'b11;
      rst_c = 1'b0;
      step(); chk("c_e1", 8'(lc), 8'b00001);
      step(); chk("c_e2", 8'(lc), 8'b00011);
      step(); chk("c_e3", 8'(lc), 8'b00111);
      step(); chk("c_e4", 8'(lc), 8'b01111);
      step(); chk("c_e5", 8'(lc), 8'b11111);
      step(); chk("c_e6", 8'(lc), 8'b00001);
      chk("c_R", 8'(rc), 8'b00000);

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
